// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle RV32I control FSM.
// Sequences fetch/decode/execute/mem/writeback, halts on illegal op or memory stall.
//
// Ports:
//   clk, rst_n            clock (rising), async active-low reset
//   instr[31:0]           instruction register contents
//   imem_ready            instruction memory data valid
//   dmem_ready            data memory access complete
//   alu_zero              ALU result == 0
//   imem_req, ir_we       fetch request, IR load strobe
//   pc_we, pc_src         PC write strobe, 0 = PC+4 / 1 = PC+imm
//   imm_typ[6:0]          opcode to the sign-extender, 0 in FETCH/HALT
//   alu_src_b, alu_op     ALU operand B select, ALU op select
//   dmem_req, dmem_we     data memory request / store
//   reg_we, wb_sel        register-file write, 0 = ALU / 1 = memory
//   state[2:0]            current state (debug)
//   illegal, timeout      sticky fault flags
//   instret[31:0]         retired-instruction count
module riscv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [6:0]  imm_typ,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int CW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_wait;
  logic          r_illegal;
  logic          r_timeout;
  logic [31:0]   r_instret;

  logic [6:0] w_opc;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_is_l;
  logic       w_is_s;
  logic       w_is_b;
  logic       w_is_lui;
  logic       w_legal;
  logic       w_src_b;
  logic [1:0] w_op;
  logic       w_wait_inc;
  logic       w_tmo_hit;
  logic       w_tmo_evt;
  logic       w_unused;

  assign w_opc    = instr[6:0];
  assign w_is_r   = (w_opc == 7'b0110011);
  assign w_is_i   = (w_opc == 7'b0010011);
  assign w_is_l   = (w_opc == 7'b0000011);
  assign w_is_s   = (w_opc == 7'b0100011);
  assign w_is_b   = (w_opc == 7'b1100011);
  assign w_is_lui = (w_opc == 7'b0110111);
  // Only beq/bne are supported: funct3[2:1] must be 00.
  assign w_legal  = w_is_r | w_is_i | w_is_l | w_is_s | w_is_lui
                  | (w_is_b & (instr[14:13] == 2'b00));
  assign w_unused = ^{instr[31:15], instr[11:7]};

  always_comb begin
    w_src_b = 1'b0;
    w_op    = 2'b00;
    unique case (1'b1)
      w_is_r:         w_op = 2'b10;
      w_is_i: begin
        w_src_b = 1'b1;
        w_op    = 2'b10;
      end
      w_is_l, w_is_s: w_src_b = 1'b1;
      w_is_lui: begin
        w_src_b = 1'b1;
        w_op    = 2'b11;
      end
      w_is_b:         w_op = 2'b01;
      default: ;
    endcase
  end

  // Stall cycles: a request is outstanding and memory is not ready.
  assign w_wait_inc =
      ((r_state == S_FETCH) && !imem_ready)
    | ((r_state == S_MEM) && !dmem_ready);
  assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_wait == TMO);
  assign w_tmo_evt = w_tmo_hit && w_wait_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (imem_ready)     w_next = S_DECODE;
        else if (w_tmo_hit) w_next = S_HALT;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_l || w_is_s) w_next = S_MEM;
        else if (w_is_b)      w_next = S_FETCH;
        else                  w_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)     w_next = w_is_l ? S_WB : S_FETCH;
        else if (w_tmo_hit) w_next = S_HALT;
      end
      S_WB:   w_next = S_FETCH;
      S_HALT: w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  // Strobes are forced low for as long as reset is held.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    imm_typ   = 7'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_DECODE: imm_typ = w_opc;
        S_EXEC: begin
          imm_typ   = w_opc;
          alu_src_b = w_src_b;
          alu_op    = w_op;
          if (w_is_b) begin
            pc_we  = 1'b1;
            pc_src = alu_zero ^ instr[12];
          end
        end
        S_MEM: begin
          imm_typ   = w_opc;
          alu_src_b = w_src_b;
          alu_op    = w_op;
          dmem_req  = 1'b1;
          dmem_we   = w_is_s;
          pc_we     = w_is_s & dmem_ready;
        end
        S_WB: begin
          imm_typ = w_opc;
          reg_we  = 1'b1;
          wb_sel  = w_is_l;
          pc_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_wait <= '0;
    else if (w_next != r_state) r_wait <= '0;
    else if (w_wait_inc)        r_wait <= r_wait + 1'b1;
  end

  // Every retirement writes the PC, so pc_we doubles as the retire strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
      if (w_tmo_evt)                       r_timeout <= 1'b1;
      if (pc_we)                           r_instret <= r_instret + 32'd1;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign instret = r_instret;

endmodule
